// File: rtl/rob_mc.sv
// rob_mc: reorder buffer with up to two in-order retirements per cycle, multi-channel
// write-back, operand lookup with write-back bypass, store-commit handshake and mispredict flush.
module rob_mc #(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = 4,
   parameter int DATA_W   = 32,
   parameter int RD_W     = 5,
   parameter int NUM_WB   = 2,
   parameter int FULL_GAP = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     is_en,
   input  logic                     is_st,
   input  logic                     is_bj,
   input  logic [RD_W-1:0]          is_rd,
   input  logic [DATA_W-1:0]        is_pc,
   input  logic [DATA_W-1:0]        is_pjt,
   output logic [TAG_W-1:0]         alloc_tag,
   input  logic [NUM_WB-1:0]        wb_en,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*DATA_W-1:0] wb_vd,
   input  logic [NUM_WB*DATA_W-1:0] wb_jt,
   input  logic [2*TAG_W-1:0]       q_tag,
   output logic [1:0]               q_rdy,
   output logic [2*DATA_W-1:0]      q_val,
   output logic                     st_cs,
   input  logic                     st_ack,
   output logic [1:0]               cm_en,
   output logic [2*RD_W-1:0]        cm_rd,
   output logic [2*TAG_W-1:0]       cm_tag,
   output logic [2*DATA_W-1:0]      cm_vd,
   output logic                     mp,
   output logic [DATA_W-1:0]        rpc,
   output logic                     full,
   output logic                     err
);

   localparam logic [TAG_W-1:0] CAP        = TAG_W'(DEPTH - 1);
   localparam logic [TAG_W-1:0] FULL_LEVEL = TAG_W'(DEPTH - 1 - FULL_GAP);
   localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

   logic [DEPTH-1:0]  rdy_q, st_q, bj_q;
   logic [RD_W-1:0]   rd_q  [DEPTH];
   logic [DATA_W-1:0] pjt_q [DEPTH];
   logic [DATA_W-1:0] vd_q  [DEPTH];
   logic [DATA_W-1:0] jt_q  [DEPTH];

   logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic                err_q, err_d, stCs_q, stCs_d, mp_q, mp_d;
   logic [1:0]          cmEn_q, cmEn_d;
   logic [2*RD_W-1:0]   cmRd_q, cmRd_d;
   logic [2*TAG_W-1:0]  cmTag_q, cmTag_d;
   logic [2*DATA_W-1:0] cmVd_q, cmVd_d;
   logic [DATA_W-1:0]   rpc_q, rpc_d;

   logic [TAG_W-1:0] head1, numCommit;
   logic             commit0, commit1, doAlloc, overflow;
   logic             unusedPc;

   assign unusedPc = ^is_pc;

   // Tag 0 means "no dependency", so the ring skips it on wrap.
   function automatic logic [TAG_W-1:0] nextTag(input logic [TAG_W-1:0] t);
      return (t == CAP) ? TAG_ONE : t + TAG_ONE;
   endfunction

   always_comb begin
      head1    = nextTag(head_q);
      commit0  = (count_q != '0) && (st_q[head_q] ? st_ack : rdy_q[head_q]);
      commit1  = commit0 && !st_q[head_q] && !bj_q[head_q] && (count_q > TAG_ONE)
                 && rdy_q[head1] && !st_q[head1] && !bj_q[head1];
      doAlloc  = is_en && (count_q != CAP);
      overflow = is_en && (count_q == CAP);
      numCommit = '0;
      if (commit1) begin
         numCommit = TAG_W'(2);
      end else if (commit0) begin
         numCommit = TAG_ONE;
      end

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q;
      stCs_d  = 1'b0;
      mp_d    = 1'b0;
      cmEn_d  = '0;
      cmRd_d  = cmRd_q;
      cmTag_d = cmTag_q;
      cmVd_d  = cmVd_q;
      rpc_d   = rpc_q;

      // The cycle mp is visible is spent flushing; nothing else is accepted.
      if (mp_q) begin
         head_d  = TAG_ONE;
         tail_d  = TAG_ONE;
         count_d = '0;
      end else begin
         if (overflow) begin
            err_d = 1'b1;
         end
         if (doAlloc) begin
            tail_d = nextTag(tail_q);
         end
         if (commit1) begin
            head_d = nextTag(head1);
         end else if (commit0) begin
            head_d = head1;
         end
         count_d = count_q + (doAlloc ? TAG_ONE : '0) - numCommit;

         if (commit0) begin
            if (st_q[head_q]) begin
               stCs_d = 1'b1;
            end else if (bj_q[head_q]) begin
               if (jt_q[head_q] != pjt_q[head_q]) begin
                  mp_d  = 1'b1;
                  rpc_d = jt_q[head_q];
               end
            end else begin
               cmEn_d[0]              = 1'b1;
               cmRd_d[RD_W-1:0]       = rd_q[head_q];
               cmTag_d[TAG_W-1:0]     = head_q;
               cmVd_d[DATA_W-1:0]     = vd_q[head_q];
            end
         end
         if (commit1) begin
            cmEn_d[1]                = 1'b1;
            cmRd_d[2*RD_W-1:RD_W]    = rd_q[head1];
            cmTag_d[2*TAG_W-1:TAG_W] = head1;
            cmVd_d[2*DATA_W-1:DATA_W] = vd_q[head1];
         end
      end
   end

   // Lowest write-back channel wins the bypass, matching operand forwarding priority.
   always_comb begin
      q_rdy = '0;
      q_val = '0;
      for (int i = 0; i < 2; i++) begin
         if (q_tag[i*TAG_W +: TAG_W] == '0) begin
            q_rdy[i] = 1'b1;
         end else begin
            q_rdy[i]                  = rdy_q[q_tag[i*TAG_W +: TAG_W]];
            q_val[i*DATA_W +: DATA_W] = vd_q[q_tag[i*TAG_W +: TAG_W]];
            for (int k = NUM_WB - 1; k >= 0; k--) begin
               if (wb_en[k] && (wb_tag[k*TAG_W +: TAG_W] == q_tag[i*TAG_W +: TAG_W])) begin
                  q_rdy[i]                  = 1'b1;
                  q_val[i*DATA_W +: DATA_W] = wb_vd[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= TAG_ONE;
         tail_q  <= TAG_ONE;
         count_q <= '0;
         err_q   <= 1'b0;
         stCs_q  <= 1'b0;
         mp_q    <= 1'b0;
         cmEn_q  <= '0;
         cmRd_q  <= '0;
         cmTag_q <= '0;
         cmVd_q  <= '0;
         rpc_q   <= '0;
         rdy_q   <= '0;
         st_q    <= '0;
         bj_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]  <= '0;
            pjt_q[i] <= '0;
            vd_q[i]  <= '0;
            jt_q[i]  <= '0;
         end
      end else if (en) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
         stCs_q  <= stCs_d;
         mp_q    <= mp_d;
         cmEn_q  <= cmEn_d;
         cmRd_q  <= cmRd_d;
         cmTag_q <= cmTag_d;
         cmVd_q  <= cmVd_d;
         rpc_q   <= rpc_d;
         if (mp_q) begin
            rdy_q <= '0;
            st_q  <= '0;
            bj_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               vd_q[i] <= '0;
               jt_q[i] <= '0;
            end
         end else begin
            if (doAlloc) begin
               rdy_q[tail_q] <= 1'b0;
               st_q[tail_q]  <= is_st;
               bj_q[tail_q]  <= is_bj;
               rd_q[tail_q]  <= is_rd;
               pjt_q[tail_q] <= is_pjt;
               vd_q[tail_q]  <= '0;
               jt_q[tail_q]  <= '0;
            end
            for (int k = 0; k < NUM_WB; k++) begin
               if (wb_en[k] && (wb_tag[k*TAG_W +: TAG_W] != '0)) begin
                  rdy_q[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
                  vd_q[wb_tag[k*TAG_W +: TAG_W]]  <= wb_vd[k*DATA_W +: DATA_W];
                  jt_q[wb_tag[k*TAG_W +: TAG_W]]  <= wb_jt[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign alloc_tag = tail_q;
   assign full      = (count_q >= FULL_LEVEL);
   assign err       = err_q;
   assign st_cs     = stCs_q & en;
   assign cm_en     = cmEn_q & {2{en}};
   assign mp        = mp_q & en;
   assign rpc       = rpc_q;
   assign cm_rd     = cmRd_q;
   assign cm_tag    = cmTag_q;
   assign cm_vd     = cmVd_q;

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: randomized bench for rob_mc; a program-order queue plus per-tag result
// arrays predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_rob_mc;

   localparam int DEPTH    = 16;
   localparam int TAG_W    = 4;
   localparam int DATA_W   = 32;
   localparam int RD_W     = 5;
   localparam int NUM_WB   = 2;
   localparam int FULL_GAP = 3;
   localparam int CAP      = DEPTH - 1;

   logic                     clk = 1'b0;
   logic                     rst, en, is_en, is_st, is_bj, st_ack;
   logic [RD_W-1:0]          is_rd;
   logic [DATA_W-1:0]        is_pc, is_pjt;
   logic [TAG_W-1:0]         alloc_tag;
   logic [NUM_WB-1:0]        wb_en;
   logic [NUM_WB*TAG_W-1:0]  wb_tag;
   logic [NUM_WB*DATA_W-1:0] wb_vd, wb_jt;
   logic [2*TAG_W-1:0]       q_tag;
   logic [1:0]               q_rdy;
   logic [2*DATA_W-1:0]      q_val;
   logic                     st_cs, mp, full, err;
   logic [1:0]               cm_en;
   logic [2*RD_W-1:0]        cm_rd;
   logic [2*TAG_W-1:0]       cm_tag;
   logic [2*DATA_W-1:0]      cm_vd;
   logic [DATA_W-1:0]        rpc;

   rob_mc #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .RD_W(RD_W),
            .NUM_WB(NUM_WB), .FULL_GAP(FULL_GAP)) dut (
      .clk(clk), .rst(rst), .en(en), .is_en(is_en), .is_st(is_st), .is_bj(is_bj),
      .is_rd(is_rd), .is_pc(is_pc), .is_pjt(is_pjt), .alloc_tag(alloc_tag),
      .wb_en(wb_en), .wb_tag(wb_tag), .wb_vd(wb_vd), .wb_jt(wb_jt),
      .q_tag(q_tag), .q_rdy(q_rdy), .q_val(q_val), .st_cs(st_cs), .st_ack(st_ack),
      .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_vd(cm_vd),
      .mp(mp), .rpc(rpc), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              tag;
      bit              st;
      bit              bj;
      bit [RD_W-1:0]   rd;
      bit [DATA_W-1:0] pjt;
   } entry_t;

   entry_t          robQ[$];
   bit              mRdy[DEPTH];
   bit [DATA_W-1:0] mVd[DEPTH];
   bit [DATA_W-1:0] mJt[DEPTH];
   int              mTail;
   bit              mErr;
   bit              eStCs, eMp;
   bit [1:0]        eCmEn;
   bit [DATA_W-1:0] eRpc;
   bit [RD_W-1:0]   eRd[2];
   int              eTag[2];
   bit [DATA_W-1:0] eVd[2];

   int nCompared   = 0;
   int nMismatched = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelClearEntries();
      robQ.delete();
      for (int i = 0; i < DEPTH; i++) begin
         mRdy[i] = 1'b0;
         mVd[i]  = '0;
         mJt[i]  = '0;
      end
      mTail = 1;
      eStCs = 1'b0;
      eMp   = 1'b0;
      eCmEn = '0;
   endtask

   function automatic int pickTag();
      if (robQ.size() == 0 || $urandom_range(0, 9) == 0) return 0;
      return robQ[$urandom_range(0, robQ.size() - 1)].tag;
   endfunction

   task automatic setIdle();
      en = 1'b1; is_en = 1'b0; is_st = 1'b0; is_bj = 1'b0; is_rd = '0;
      is_pc = '0; is_pjt = '0; wb_en = '0; wb_tag = '0; wb_vd = '0; wb_jt = '0;
      q_tag = '0; st_ack = 1'b0;
   endtask

   // fill=1: allocate plain instructions with nothing completing, to reach capacity.
   task automatic applyStimulus(input bit fill);
      int r;
      setIdle();
      is_rd  = RD_W'($urandom);
      is_pc  = $urandom;
      is_pjt = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h104;
      if (fill) begin
         is_en = 1'b1;
      end else begin
         en     = ($urandom_range(0, 9) != 0);
         is_en  = ($urandom_range(0, 9) < 6);
         r      = $urandom_range(0, 99);
         is_st  = (r < 15);
         is_bj  = (r >= 15) && (r < 27);
         st_ack = $urandom_range(0, 1);
         for (int k = 0; k < NUM_WB; k++) begin
            wb_en[k]                    = ($urandom_range(0, 9) < 4);
            wb_tag[k*TAG_W +: TAG_W]    = TAG_W'(pickTag());
            wb_vd[k*DATA_W +: DATA_W]   = $urandom;
            wb_jt[k*DATA_W +: DATA_W]   = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h104;
         end
         if ($urandom_range(0, 4) == 0) wb_tag[TAG_W +: TAG_W] = wb_tag[0 +: TAG_W];
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 1) != 0) q_tag[i*TAG_W +: TAG_W] = wb_tag[0 +: TAG_W];
            else q_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH - 1));
         end
      end
   endtask

   task automatic compareCycle();
      int              qt;
      bit              expR, found;
      bit [DATA_W-1:0] expV;
      checkOutput("st_cs", st_cs, en ? eStCs : 1'b0);
      checkOutput("cm_en", cm_en, en ? eCmEn : 2'b00);
      checkOutput("mp", mp, en ? eMp : 1'b0);
      if (en && eMp) checkOutput("rpc", rpc, eRpc);
      for (int i = 0; i < 2; i++) begin
         if (en && eCmEn[i]) begin
            checkOutput($sformatf("cm_rd%0d", i), cm_rd[i*RD_W +: RD_W], eRd[i]);
            checkOutput($sformatf("cm_tag%0d", i), cm_tag[i*TAG_W +: TAG_W], eTag[i]);
            checkOutput($sformatf("cm_vd%0d", i), cm_vd[i*DATA_W +: DATA_W], eVd[i]);
         end
      end
      checkOutput("full", full, robQ.size() >= CAP - FULL_GAP);
      checkOutput("alloc_tag", alloc_tag, mTail);
      checkOutput("err", err, mErr);
      for (int i = 0; i < 2; i++) begin
         qt = int'(q_tag[i*TAG_W +: TAG_W]);
         found = 1'b0;
         if (qt == 0) begin
            expR = 1'b1;
            expV = '0;
         end else begin
            expR = mRdy[qt];
            expV = mVd[qt];
            for (int k = 0; k < NUM_WB; k++) begin
               if (!found && wb_en[k] && int'(wb_tag[k*TAG_W +: TAG_W]) == qt) begin
                  found = 1'b1;
                  expR  = 1'b1;
                  expV  = wb_vd[k*DATA_W +: DATA_W];
               end
            end
         end
         checkOutput($sformatf("q_rdy%0d", i), q_rdy[i], expR);
         checkOutput($sformatf("q_val%0d", i), q_val[i*DATA_W +: DATA_W], expV);
      end
   endtask

   // Advance the reference by one clock edge using this cycle's inputs.
   task automatic modelStep();
      int     n, t;
      bit     c0, c1;
      entry_t h0, h1;
      if (!en) return;
      if (eMp) begin
         modelClearEntries();
         return;
      end
      n = robQ.size();
      c0 = 1'b0;
      c1 = 1'b0;
      eStCs = 1'b0;
      eMp   = 1'b0;
      eCmEn = '0;
      if (n >= 1) begin
         h0 = robQ[0];
         c0 = h0.st ? st_ack : mRdy[h0.tag];
         if (c0) begin
            if (h0.st) begin
               eStCs = 1'b1;
            end else if (h0.bj) begin
               if (mJt[h0.tag] != h0.pjt) begin
                  eMp  = 1'b1;
                  eRpc = mJt[h0.tag];
               end
            end else begin
               eCmEn[0] = 1'b1;
               eRd[0]   = h0.rd;
               eTag[0]  = h0.tag;
               eVd[0]   = mVd[h0.tag];
            end
         end
         if (c0 && !h0.st && !h0.bj && n >= 2) begin
            h1 = robQ[1];
            if (mRdy[h1.tag] && !h1.st && !h1.bj) begin
               c1       = 1'b1;
               eCmEn[1] = 1'b1;
               eRd[1]   = h1.rd;
               eTag[1]  = h1.tag;
               eVd[1]   = mVd[h1.tag];
            end
         end
      end
      if (c0) void'(robQ.pop_front());
      if (c1) void'(robQ.pop_front());
      if (is_en) begin
         if (n < CAP) begin
            robQ.push_back('{tag: mTail, st: is_st, bj: is_bj, rd: is_rd, pjt: is_pjt});
            mRdy[mTail] = 1'b0;
            mVd[mTail]  = '0;
            mJt[mTail]  = '0;
            mTail = (mTail == DEPTH - 1) ? 1 : mTail + 1;
         end else begin
            mErr = 1'b1;
         end
      end
      for (int k = 0; k < NUM_WB; k++) begin
         t = int'(wb_tag[k*TAG_W +: TAG_W]);
         if (wb_en[k] && t != 0) begin
            mRdy[t] = 1'b1;
            mVd[t]  = wb_vd[k*DATA_W +: DATA_W];
            mJt[t]  = wb_jt[k*DATA_W +: DATA_W];
         end
      end
   endtask

   task automatic runCycle(input bit fill);
      applyStimulus(fill);
      #1;
      compareCycle();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   // Reset is asserted with en low to show it takes priority over the stall.
   task automatic doReset();
      setIdle();
      en  = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      en  = 1'b1;
      modelClearEntries();
      mErr = 1'b0;
      #1;
      checkOutput("rst_alloc_tag", alloc_tag, 1);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_cm_en", cm_en, 0);
      checkOutput("rst_st_cs", st_cs, 0);
      checkOutput("rst_mp", mp, 0);
      checkOutput("rst_rpc", rpc, 0);
      checkOutput("rst_cm_tag", cm_tag, 0);
      checkOutput("rst_cm_vd", cm_vd, 0);
   endtask

   initial begin
      rst = 1'b1;
      setIdle();
      doReset();
      for (int c = 0; c < 17; c++) runCycle(1'b1);
      for (int c = 0; c < 1500; c++) runCycle(1'b0);
      doReset();
      for (int c = 0; c < 1500; c++) runCycle(1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/rob_mc.md
Name: rob_mc

Overview:
- Parametrised reorder buffer: in-order retirement of up to two instructions per cycle.
- NUM_WB result write-back channels and a store-commit handshake.
- Sits between issue/register-rename and the RS/LSB/register file; drives misprediction redirect to IF.
- Tag 0 is reserved as "no dependency / value ready"; usable tags are 1..DEPTH-1.

Parameters:
DEPTH, 16, entry array size (power of 2, >=4); capacity CAP = DEPTH-1
TAG_W, 4, log2(DEPTH)
DATA_W, 32, value/PC width
RD_W, 5, architectural register index width
NUM_WB, 2, number of write-back channels
FULL_GAP, 3, early-full margin for in-flight fetches (0..CAP-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global stall (0 = hold all state; outputs' one-cycle pulses forced 0)
is_en  in  1  allocate entry at tail
is_st  in  1  entry is a store
is_bj  in  1  entry is branch/jump
is_rd  in  RD_W  destination register
is_pc  in  DATA_W  instruction PC
is_pjt  in  DATA_W  predicted next PC
alloc_tag  out  TAG_W  tag given to the next allocation (= tail)
wb_en  in  NUM_WB  per-channel result valid
wb_tag  in  NUM_WB*TAG_W  per-channel tag, channel k at [k*TAG_W +: TAG_W]
wb_vd  in  NUM_WB*DATA_W  result value
wb_jt  in  NUM_WB*DATA_W  resolved next PC (meaningful for bj entries)
q_tag  in  2*TAG_W  two operand lookup tags
q_rdy  out  2  lookup ready (combinational)
q_val  out  2*DATA_W  lookup value (combinational)
st_cs  out  1  commit-store pulse to LSB
st_ack  in  1  LSB can accept a store commit this cycle
cm_en  out  2  register-commit slot valid (registered)
cm_rd  out  2*RD_W  commit destination register
cm_tag  out  2*TAG_W  commit tag (for rename clear)
cm_vd  out  2*DATA_W  commit value
mp  out  1  misprediction pulse
rpc  out  DATA_W  redirect PC, valid with mp
full  out  1  early-full to IF
err  out  1  sticky overflow flag

Behaviour:
- Reset (rst=1, regardless of en): all entries invalid/not-ready.
  - head = tail = 1, count = 0.
  - Outputs st_cs, cm_en, mp, rpc, cm_*, err = 0.
  - full = 0 when FULL_GAP < CAP.
- Tag wrap: next(t) = t+1, or 1 when t == DEPTH-1; tag 0 is never allocated.
- full = (count >= CAP-FULL_GAP), combinational from registered count.
- Allocation:
  - is_en with count < CAP writes the entry at tail (rdy=0, vd=0, jt=0) and advances tail.
  - is_en with count == CAP: entry dropped, err set (sticky until rst).
- Write-back: each wb_en[k] sets rdy, vd, jt of entry wb_tag[k].
  - Equal tags on two channels: the higher k wins.
  - wb to tag 0 ignored.
- Lookup (combinational): q_tag == 0 -> rdy=1, val=0.
  - Otherwise the lowest-k matching wb_en bypasses wb_vd.
  - Otherwise the entry's rdy/vd.
- Commit slot 0 (head, count >= 1):
  - store: commits when st_ack; st_cs=1 next cycle.
  - non-store: commits when rdy.
  - bj: if jt != pjt then mp=1, rpc=jt next cycle; no cm_en.
  - other: cm_en[0]=1 with rd, tag, vd next cycle.
- Commit slot 1 (next(head), count >= 2): commits only if all hold:
  - slot 0 commits this cycle;
  - slot 0 is neither bj nor store;
  - slot 1 entry is rdy, not store, not bj.
  - Gives cm_en[1] with its fields.
- Pointer/count update: head advances by the number committed; count += alloc - committed, all in the same cycle.
- Simultaneous events:
  - Allocation and 2 commits at count==CAP are legal; allocation uses pre-update count.
  - A wb in the same cycle as an entry's commit check is not seen by the check (next cycle).
- mp handling: mp is high exactly one cycle. During that cycle the ROB flushes (same state as reset except err is kept) and ignores is_en and wb_en.
- en=0: no state change; st_cs, cm_en, mp driven 0. rst has priority over en.

Test Plan:
- DEPTH=16, GAP=3: allocate 12 entries, no commits -> full rises when count=12, alloc_tag=13; 3 more -> count=15, tags 13,14,15. 16th -> dropped, err=1.
- Wrap: after 15 allocs and 15 commits, next alloc_tag=1, never 0; commit order continues 15 -> 1.
- Dual commit: tags 1,2 non-bj, both wb'd (vd 0x11, 0x22) -> next cycle cm_en=2'b11, cm_tag={2,1}, head=3.
- Store stall: head store, st_ack=0 for 3 cycles -> no commit, st_cs=0. st_ack=1 -> st_cs pulse one cycle later, only slot 0 commits.
- Mispredict: bj tag 4 pjt=0x100, wb_jt=0x200 -> mp=1, rpc=0x200 one cycle after commit. Following cycle count=0, head=tail=1, concurrent is_en ignored.
- Bypass/collision: wb ch0 and ch1 both to tag 5 (0xA, 0xB) with q_tag=5 -> q_val=0xA same cycle; stored vd=0xB. q_tag=0 -> q_rdy=1, q_val=0.
